crc_recv: RTL and testbench
===========================

Name: crc_recv

Overview:
Receive-side counterpart of the CRC transmitter. Sits directly downstream of it on the 32-bit word stream.
- Accepts frames of FRAME_LEN payload words followed by one CRC word, and runs CRC-32 over all FRAME_LEN+1 words.
- Buffers the payload internally and releases it downstream only if the residue is zero; failed frames are dropped.
- Reports pass/fail per frame and keeps error counters.

Parameters:
DATA_WIDTH, 32, word width; only 32 is supported.
FRAME_LEN, 4, payload words per frame, range 1..255. The CRC word is extra.
CRC_POLY, 32'h04C11DB7, generator polynomial. Non-reflected, MSB-first.
CRC_INIT, 32'hFFFFFFFF, CRC register value at the start of each frame. There is no final XOR.

Ports:
axis_aclk  in  1  clock; all logic on the rising edge.
axis_aresetn  in  1  asynchronous, active-high reset (1 = reset asserted), despite the name.
data_in  in  32  word from the transmitter: payload words, then the CRC word.
data_in_valid  in  1  data_in is valid this cycle. The transmitter has no backpressure.
in_ready  out  1  1 = a word is accepted when data_in_valid=1.
data_out  out  32  verified payload word.
data_out_valid  out  1  data_out is valid.
data_out_ready  in  1  downstream accepts data_out when valid&ready.
data_out_last  out  1  marks the final payload word of a frame.
crc_done  out  1  one-cycle pulse when a frame check completes.
crc_ok  out  1  result of the check; valid while crc_done=1, held until the next crc_done.
overrun  out  1  sticky; set when data_in_valid=1 while in_ready=0. Cleared only by reset.
err_count  out  16  count of frames that failed the check; saturates at 16'hFFFF.

Behaviour:
- Reset (async assert, sync release): state=RECV, word counter=0, CRC register=CRC_INIT, buffer pointers=0. Outputs in reset:
  - in_ready=1
  - data_out=0, data_out_valid=0, data_out_last=0
  - crc_done=0, crc_ok=0
  - overrun=0, err_count=0
- Reset asserted mid-frame or mid-drain discards all buffered words with no crc_done pulse.
- CRC update is combinational over one 32-bit word per accepted beat: data bit 31 is fed first, shifting against CRC_POLY.
- State RECV (in_ready=1):
  - Each accepted word updates the CRC register and increments the word counter.
  - Words with counter < FRAME_LEN are also written to the buffer (depth FRAME_LEN, registers).
  - Counter == FRAME_LEN marks the CRC word: CRC is updated, nothing is written, go to CHECK next cycle.
- State CHECK (in_ready=0; one cycle):
  - crc_done=1 and crc_ok=(CRC register == 0).
  - If ok, go to DRAIN. Otherwise err_count+1 (saturating) and go to DROP.
  - Counter is reset to 0 and the CRC register to CRC_INIT.
- State DRAIN (in_ready=0):
  - data_out_valid=1, driving the buffer word at the read pointer. data_out_last=1 on word FRAME_LEN-1.
  - The pointer advances only on valid&ready. data_out/valid/last are stable while ready=0.
  - After the last word transfers, go to RECV next cycle with in_ready=1.
- State DROP (in_ready=0; one cycle): buffer pointers are cleared, then go to RECV.
- Latency:
  - CRC word accepted at cycle N: crc_done at N+1.
  - First data_out_valid at N+2. With ready held at 1, the last word transfers at N+1+FRAME_LEN.
  - in_ready returns to 1 at N+2+FRAME_LEN (good frame) or N+3 (bad frame).
- Overrun: words arriving while in_ready=0 are discarded and set overrun. Frame alignment is not re-acquired; the next accepted word is treated as word 0 of a new frame.
- data_in_valid=0 in RECV holds all state; gaps between words are allowed.
- FRAME_LEN=1: buffer of one entry; the frame is two words in total.

Test Plan:
1. Reset, then send payload 5,3,678,76 plus the correct CRC word from the bench model (CRC-32/MPEG-2 over the 4 words), ready=1 → crc_done pulse with crc_ok=1 one cycle after the CRC word. Words 5,3,678,76 appear on consecutive cycles starting 2 cycles after the CRC word, data_out_last on 76, err_count=0.
2. Same frame with CRC word bit 0 flipped → crc_ok=0, err_count=1, no data_out_valid, in_ready=1 again 3 cycles after the CRC word.
3. Good frame with data_out_ready toggling 1,0,0,1,… → every word transfers exactly once, in order. Output is stable while stalled, and in_ready stays 0 until the last word is taken.
4. Drive data_in_valid=1 with value 89 during CHECK/DRAIN → overrun=1 and stays 1. 89 never appears on data_out. The next frame sent after in_ready=1 passes.
5. Assert axis_aresetn=1 after 2 payload words, release, then send a full good frame → no crc_done for the aborted frame, the new frame passes, and all outputs are at reset values during reset.
6. Good frame with 3-cycle valid gaps between words, then 2 back-to-back good frames → all pass, outputs identical to the gapless case.

Source files
------------

// File: rtl/crc_recv_if.sv
// Word-stream bundle between the CRC transmitter, crc_recv and its downstream sink.
// Handshakes: an upstream word moves when data_in_valid & in_ready, with no backpressure on the sender.
// A downstream word moves when data_out_valid & data_out_ready.
interface crc_recv_if #(
  parameter int DATA_WIDTH = 32
);
  logic [DATA_WIDTH-1:0] data_in;
  logic                  data_in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] data_out;
  logic                  data_out_valid;
  logic                  data_out_ready;
  logic                  data_out_last;
  logic                  crc_done;
  logic                  crc_ok;
  logic                  overrun;
  logic [15:0]           err_count;
  logic [1:0]            dbg_state;

  modport master (
    output data_in, data_in_valid, data_out_ready,
    input  in_ready, data_out, data_out_valid, data_out_last,
           crc_done, crc_ok, overrun, err_count, dbg_state
  );

  modport slave (
    input  data_in, data_in_valid, data_out_ready,
    output in_ready, data_out, data_out_valid, data_out_last,
           crc_done, crc_ok, overrun, err_count, dbg_state
  );
endinterface

// File: rtl/crc_recv.sv
// CRC-32 frame receiver: buffers FRAME_LEN payload words, checks the residue after the CRC word,
// and forwards the payload only for frames that pass.
module crc_recv #(
  parameter int          DATA_WIDTH = 32,
  parameter int          FRAME_LEN  = 4,
  parameter logic [31:0] CRC_POLY   = 32'h04C11DB7,
  parameter logic [31:0] CRC_INIT   = 32'hFFFFFFFF
) (
  input  logic     axis_aclk,
  input  logic     axis_aresetn,
  crc_recv_if.slave bus
);

  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  typedef enum logic [1:0] {
    S_RECV  = 2'd0,
    S_CHECK = 2'd1,
    S_DRAIN = 2'd2,
    S_DROP  = 2'd3
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [31:0]           crc_q, crc_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic                  crc_ok_q, crc_ok_d;
  logic                  overrun_q, overrun_d;
  logic [15:0]           err_q, err_d;
  logic [DATA_WIDTH-1:0] mem_q [FRAME_LEN];

  logic                  in_ready_c;
  logic                  out_valid_c;
  logic                  out_last_c;
  logic                  done_c;
  logic                  residue_zero;
  logic                  wr_en;
  logic [PW-1:0]         wr_idx;

  // One word per beat, MSB first, shifted against the generator polynomial.
  function automatic logic [31:0] crc_step(input logic [31:0] c, input logic [DATA_WIDTH-1:0] d);
    logic [31:0] r;
    r = c;
    for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
      if (r[31] ^ d[i]) r = {r[30:0], 1'b0} ^ CRC_POLY;
      else              r = {r[30:0], 1'b0};
    end
    return r;
  endfunction

  assign residue_zero = (crc_q == 32'd0);
  assign wr_idx       = cnt_q[PW-1:0];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    crc_d       = crc_q;
    rd_ptr_d    = rd_ptr_q;
    crc_ok_d    = crc_ok_q;
    err_d       = err_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    out_last_c  = 1'b0;
    done_c      = 1'b0;
    wr_en       = 1'b0;

    case (state_q)
      S_RECV: begin
        in_ready_c = 1'b1;
        if (bus.data_in_valid) begin
          crc_d = crc_step(crc_q, bus.data_in);
          if (cnt_q == CW'(FRAME_LEN)) begin
            state_d = S_CHECK;
          end else begin
            cnt_d = cnt_q + CW'(1);
            wr_en = 1'b1;
          end
        end
      end
      S_CHECK: begin
        done_c   = 1'b1;
        crc_ok_d = residue_zero;
        cnt_d    = '0;
        crc_d    = CRC_INIT;
        if (residue_zero) begin
          state_d = S_DRAIN;
        end else begin
          state_d = S_DROP;
          if (err_q != 16'hFFFF) err_d = err_q + 16'd1;
        end
      end
      S_DRAIN: begin
        out_valid_c = 1'b1;
        out_last_c  = (rd_ptr_q == PW'(FRAME_LEN - 1));
        if (bus.data_out_ready) begin
          if (out_last_c) begin
            rd_ptr_d = '0;
            state_d  = S_RECV;
          end else begin
            rd_ptr_d = rd_ptr_q + PW'(1);
          end
        end
      end
      S_DROP: begin
        rd_ptr_d = '0;
        state_d  = S_RECV;
      end
      default: state_d = S_RECV;
    endcase

    // Words offered while busy are lost; alignment restarts at the next accepted word.
    overrun_d = overrun_q | (bus.data_in_valid & ~in_ready_c);
  end

  always_ff @(posedge axis_aclk or posedge axis_aresetn) begin
    if (axis_aresetn) begin
      state_q   <= S_RECV;
      cnt_q     <= '0;
      crc_q     <= CRC_INIT;
      rd_ptr_q  <= '0;
      crc_ok_q  <= 1'b0;
      overrun_q <= 1'b0;
      err_q     <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      crc_q     <= crc_d;
      rd_ptr_q  <= rd_ptr_d;
      crc_ok_q  <= crc_ok_d;
      overrun_q <= overrun_d;
      err_q     <= err_d;
    end
  end

  // Payload storage needs no reset: it is only observable while draining a freshly written frame.
  always_ff @(posedge axis_aclk) begin
    if (wr_en) mem_q[wr_idx] <= bus.data_in;
  end

  assign bus.in_ready       = in_ready_c;
  assign bus.data_out_valid = out_valid_c;
  assign bus.data_out_last  = out_last_c;
  assign bus.data_out       = (state_q == S_DRAIN) ? mem_q[rd_ptr_q] : '0;
  assign bus.crc_done       = done_c;
  assign bus.crc_ok         = done_c ? residue_zero : crc_ok_q;
  assign bus.overrun        = overrun_q;
  assign bus.err_count      = err_q;
  assign bus.dbg_state      = state_q;

endmodule

// File: tb/tb_crc_recv.sv
// Directed and randomized frames against a long-division CRC model and an output scoreboard.
module tb_crc_recv;

  localparam int          FL   = 4;
  localparam logic [31:0] POLY = 32'h04C11DB7;
  localparam logic [31:0] INIT = 32'hFFFFFFFF;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   ready_mode = 0;

  crc_recv_if #(.DATA_WIDTH(32)) bus ();

  crc_recv #(.DATA_WIDTH(32), .FRAME_LEN(FL), .CRC_POLY(POLY), .CRC_INIT(INIT)) dut (
    .axis_aclk   (clk),
    .axis_aresetn(rst),
    .bus         (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  logic [31:0] exp_q[$];
  logic        exp_last_q[$];
  logic [31:0] got_q[$];
  logic        got_last_q[$];
  int          got_cyc_q[$];
  logic        done_ok_q[$];
  int          done_cyc_q[$];
  int          exp_err = 0;
  logic        exp_ovr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Textbook definition: init XORed into the leading 32 message bits, 32 zeros appended,
  // remainder of polynomial long division by x^32 + POLY.
  function automatic logic [31:0] model_crc(input logic [31:0] w[$]);
    bit          m[$];
    logic [32:0] g;
    logic [31:0] iv;
    logic [31:0] r;
    g  = {1'b1, POLY};
    iv = INIT;
    foreach (w[i]) for (int b = 31; b >= 0; b--) m.push_back(w[i][b]);
    for (int b = 0; b < 32; b++) m[b] = m[b] ^ iv[31-b];
    repeat (32) m.push_back(1'b0);
    for (int i = 0; i < m.size() - 32; i++)
      if (m[i]) for (int k = 0; k < 33; k++) m[i+k] = m[i+k] ^ g[32-k];
    for (int k = 0; k < 32; k++) r[31-k] = m[m.size()-32+k];
    return r;
  endfunction

  // Downstream sink: ready pattern chosen by ready_mode.
  initial begin
    int rc;
    rc = 0;
    bus.data_out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rc++;
      case (ready_mode)
        0:       bus.data_out_ready = 1'b1;
        1:       bus.data_out_ready = (rc % 3 == 0);
        default: bus.data_out_ready = 1'($urandom_range(0, 1));
      endcase
    end
  end

  // Monitor: records transfers and crc_done pulses, checks stall stability.
  logic        stall_v = 1'b0;
  logic [31:0] stall_d;
  logic        stall_l;
  always @(negedge clk) begin
    if (rst) begin
      stall_v = 1'b0;
    end else begin
      if (stall_v) begin
        chk("stall_valid", {31'd0, bus.data_out_valid}, 32'd1);
        chk("stall_data", bus.data_out, stall_d);
        chk("stall_last", {31'd0, bus.data_out_last}, {31'd0, stall_l});
      end
      if (bus.data_out_valid) chk("in_ready_low_drain", {31'd0, bus.in_ready}, 32'd0);
      if (bus.data_out_valid && bus.data_out_ready) begin
        got_q.push_back(bus.data_out);
        got_last_q.push_back(bus.data_out_last);
        got_cyc_q.push_back(cyc);
      end
      if (bus.crc_done) begin
        done_ok_q.push_back(bus.crc_ok);
        done_cyc_q.push_back(cyc);
      end
      stall_v = bus.data_out_valid && !bus.data_out_ready;
      stall_d = bus.data_out;
      stall_l = bus.data_out_last;
    end
  end

  task automatic drive_beat(input logic [31:0] w);
    bus.data_in       = w;
    bus.data_in_valid = 1'b1;
    @(posedge clk);
    #1;
    bus.data_in_valid = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_in_ready"}, {31'd0, bus.in_ready}, 32'd1);
    chk({tag, "_data_out"}, bus.data_out, 32'd0);
    chk({tag, "_valid"}, {31'd0, bus.data_out_valid}, 32'd0);
    chk({tag, "_last"}, {31'd0, bus.data_out_last}, 32'd0);
    chk({tag, "_done"}, {31'd0, bus.crc_done}, 32'd0);
    chk({tag, "_ok"}, {31'd0, bus.crc_ok}, 32'd0);
    chk({tag, "_overrun"}, {31'd0, bus.overrun}, 32'd0);
    chk({tag, "_err"}, {16'd0, bus.err_count}, 32'd0);
  endtask

  task automatic compare_outputs();
    chk("out_count", got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk("out_data", got_q.pop_front(), exp_q.pop_front());
      chk("out_last", {31'd0, got_last_q.pop_front()}, {31'd0, exp_last_q.pop_front()});
    end
    exp_q.delete(); exp_last_q.delete();
    got_q.delete(); got_last_q.delete(); got_cyc_q.delete();
  endtask

  task automatic run_frame(input logic [31:0] p[$], input bit corrupt, input int gap,
                           input bit timed, input bit inject);
    logic [31:0] crc;
    int          acc, ret, dcyc;
    logic        ok;
    crc = model_crc(p);
    if (corrupt) crc = crc ^ 32'd1;
    if (!corrupt) begin
      foreach (p[i]) begin
        exp_q.push_back(p[i]);
        exp_last_q.push_back(i == FL - 1);
      end
    end else if (exp_err < 16'hFFFF) begin
      exp_err++;
    end
    foreach (p[i]) begin
      drive_beat(p[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
    drive_beat(crc);
    acc = cyc;
    if (inject) begin
      bus.data_in       = 32'd89;
      bus.data_in_valid = 1'b1;
      repeat (3) begin @(posedge clk); #1; end
      bus.data_in_valid = 1'b0;
      exp_ovr = 1'b1;
    end
    ret = -1;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (bus.in_ready) begin ret = cyc; break; end
    end
    chk("ready_back_timeout", {31'd0, ret != -1}, 32'd1);
    chk("done_pulses", done_ok_q.size(), 1);
    if (done_ok_q.size() > 0) begin
      ok   = done_ok_q.pop_front();
      dcyc = done_cyc_q.pop_front();
      chk("crc_ok", {31'd0, ok}, {31'd0, !corrupt});
      chk("done_cyc", dcyc, acc);
    end
    done_ok_q.delete(); done_cyc_q.delete();
    chk("crc_ok_held", {31'd0, bus.crc_ok}, {31'd0, !corrupt});
    chk("err_count", {16'd0, bus.err_count}, exp_err);
    chk("overrun", {31'd0, bus.overrun}, {31'd0, exp_ovr});
    if (timed) chk("ready_back_cyc", ret, corrupt ? acc + 2 : acc + 1 + FL);
    if (timed && !corrupt && got_cyc_q.size() > 0) chk("first_out_cyc", got_cyc_q[0], acc + 1);
    if (!corrupt && got_cyc_q.size() > 0) chk("ready_after_last", ret, got_cyc_q[$] + 1);
    compare_outputs();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] p[$];
    logic [31:0] fixed[$];
    bus.data_in       = '0;
    bus.data_in_valid = 1'b0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("rst0");
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Known good frame, then the same frame with a damaged CRC word.
    fixed = '{32'd5, 32'd3, 32'd678, 32'd76};
    run_frame(fixed, 1'b0, 0, 1'b1, 1'b0);
    run_frame(fixed, 1'b1, 0, 1'b1, 1'b0);

    // Stalling sink.
    ready_mode = 1;
    p.delete();
    repeat (FL) p.push_back($urandom);
    run_frame(p, 1'b0, 0, 1'b0, 1'b0);
    ready_mode = 0;

    // Words offered during CHECK/DRAIN are dropped and flag overrun.
    run_frame(fixed, 1'b0, 0, 1'b1, 1'b1);
    p.delete();
    repeat (FL) p.push_back($urandom);
    run_frame(p, 1'b0, 0, 1'b1, 1'b0);

    // Reset mid-frame.
    drive_beat(32'h1111_0000);
    drive_beat(32'h2222_0000);
    rst = 1'b1;
    #2;
    check_reset_outputs("rst_mid");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_err = 0;
    exp_ovr = 1'b0;
    chk("rst_no_done", done_ok_q.size(), 0);
    chk("rst_no_out", got_q.size(), 0);
    run_frame(fixed, 1'b0, 0, 1'b1, 1'b0);

    // Gapped input, then back-to-back frames.
    run_frame(fixed, 1'b0, 3, 1'b0, 1'b0);
    run_frame(fixed, 1'b0, 0, 1'b1, 1'b0);
    run_frame(fixed, 1'b0, 0, 1'b1, 1'b0);

    // Random payloads, random damage, random gaps and sink readiness.
    ready_mode = 2;
    for (int f = 0; f < 10; f++) begin
      p.delete();
      repeat (FL) p.push_back($urandom);
      run_frame(p, ($urandom_range(0, 3) == 0), $urandom_range(0, 2), 1'b0, 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
